mem_write_checker: RTL and testbench
====================================

MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of the observed write-data bus.
REQ-002 SHALL have parameter ADDR_W, default 16, width of the observed data address.
REQ-003 SHALL have parameter DEPTH, default 8, number of expected-write queue entries (power of 2, >=2).
REQ-004 SHALL have parameter CNT_W, default 8, width of the match and error counters.
REQ-005 SHALL have parameter TIMEOUT, default 1024, maximum idle cycles between writes while running.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 memwrite  in  1  DUT store strobe; one write per asserted cycle.
REQ-009 dataadr  in  ADDR_W  DUT store address.
REQ-010 writedata  in  DATA_W  DUT store data.
REQ-011 exp_valid / exp_ready  in / out  1  expected-entry push handshake.
REQ-012 exp_addr, exp_data  in  ADDR_W, DATA_W  expected store address and data.
REQ-013 start  in  1  one-cycle pulse that arms checking.
REQ-014 done, pass, fail  out  1  completion status flags.
REQ-015 match_count, err_count  out  CNT_W  saturating counters.
REQ-016 first_err_addr, first_err_data  out  ADDR_W, DATA_W  observed values at the first error.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; reset enters IDLE.
REQ-018 IDLE->RUN on start; RUN->DONE when the queue is empty after a write is consumed, or on timeout; DONE->RUN on start, which also clears the counters, first_err_* and done/pass/fail.
REQ-019 SHALL ignore start while in RUN.
REQ-020 push SHALL occur when exp_valid && exp_ready; exp_ready = !full in every state.
REQ-021 In RUN, SHALL sample memwrite, dataadr and writedata on the rising clk edge and pop the queue head in the same cycle; the comparison result is visible on the counters one cycle later.
REQ-022 An address and data match SHALL increment match_count; any mismatch SHALL increment err_count.
REQ-023 A write with an empty queue SHALL count as an error ("unexpected write").
REQ-024 A push and a pop in the same cycle SHALL both take effect when the queue is neither full nor empty; with an empty queue there is no bypass, so REQ-023 applies.
REQ-025 A push while full is not accepted because exp_ready=0; no data is lost or overwritten.
REQ-026 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 first_err_* SHALL latch only on the first error after start; later errors do not update them.
REQ-028 memwrite in IDLE or DONE SHALL be ignored and cause no pop or count.
REQ-029 done=1 in DONE; pass = done && err_count==0; fail = done && err_count!=0.
REQ-030 If start arrives with an empty queue, the FSM SHALL stay in RUN until the first write (an error) or timeout.

Reset
REQ-031 Reset SHALL clear the queue pointers, counters, first_err_* and done/pass/fail to 0, and set exp_ready=1.
REQ-032 Reset asserted mid-RUN SHALL abort immediately to IDLE and discard queued entries.

Configuration
REQ-033 Macro MEM_WRITE_CHECKER_TIMEOUT_EN defined: a cycle counter in RUN resets on each memwrite; reaching TIMEOUT increments err_count and enters DONE.
REQ-034 MEM_WRITE_CHECKER_TIMEOUT_EN undefined: no timeout counter exists, and RUN is left only per REQ-018 queue-empty rule.

Structure
REQ-035 A shared package mwc_pkg SHALL hold the FSM state typedef and the default parameter constants.
REQ-036 The expected queue SHALL be a sub-module mwc_fifo (synchronous FIFO, DEPTH x (ADDR_W+DATA_W), full/empty outputs).

Verification
REQ-037 Push {0x001C,0xB9}, start, then write 0x001C/0xB9 -> done=1, pass=1, match_count=1, err_count=0.
REQ-038 Push {0x001C,0xB9}, start, then write 0x001C/0xB8 -> fail=1, err_count=1, first_err_addr=0x001C, first_err_data=0xB8.
REQ-039 Push 8 entries, then assert exp_valid for a 9th -> exp_ready=0; the 9th is not accepted; 8 matching writes -> match_count=8, pass.
REQ-040 Start with an empty queue, then write 0x0010/0x01 -> err_count=1, done=1, fail=1.
REQ-041 With TIMEOUT_EN and TIMEOUT=16: push one entry, start, no writes -> done with err_count=1 at cycle 16; without TIMEOUT_EN -> remains in RUN.
REQ-042 Assert reset mid-RUN with 3 entries queued -> state IDLE, all outputs 0, exp_ready=1; a subsequent write is ignored.

Source files
------------

// File: rtl/mwc_pkg.sv
// Shared definitions for the memory-write checker.
//   state_t      : checker FSM encoding (IDLE / RUN / DONE)
//   DEF_*        : default parameter values used by the interface,
//                  the expected-write FIFO and the top level
package mwc_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_write_checker_if.sv
// Bus bundle between a store-issuing DUT/testbench and the checker.
//   memwrite, dataadr, writedata : observed store strobe, address and data
//   exp_valid, exp_addr, exp_data: expected-entry push request
//   exp_ready                    : checker can accept an expected entry
// Modports: master drives stores and pushes, slave is the checker.
interface mem_write_checker_if
    import mwc_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;
    logic              exp_valid;
    logic              exp_ready;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    modport master (
        output memwrite, dataadr, writedata,
        output exp_valid, exp_addr, exp_data,
        input  exp_ready
    );

    modport slave (
        input  memwrite, dataadr, writedata,
        input  exp_valid, exp_addr, exp_data,
        output exp_ready
    );

endinterface

// File: rtl/mwc_fifo.sv
// Synchronous FIFO holding expected {addr,data} entries.
//   clk, reset        : clock, async active-high reset (empties the queue)
//   push, push_data   : write an entry (ignored when full)
//   pop, pop_data     : drop the head entry (ignored when empty); pop_data
//                       always shows the current head
//   full, empty, count: occupancy status
module mwc_fifo
    import mwc_pkg::*;
#(
    parameter  int WIDTH = DEF_ADDR_W + DEF_DATA_W,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mem_write_checker.sv
// Scoreboard that compares observed stores against a queue of expected
// {addr,data} entries and reports match/error counts and pass/fail.
//   clk, reset                     : clock, async active-high reset
//   bus (slave)                    : observed stores + expected-entry push
//   start                          : pulse that arms checking (ignored in RUN)
//   done, pass, fail               : completion status
//   match_count, err_count         : saturating counters
//   first_err_addr, first_err_data : observed store at the first error
// Optional build macro MEM_WRITE_CHECKER_TIMEOUT_EN: an idle-cycle timer in
// RUN that counts an error and finishes after TIMEOUT cycles without a store.
//
// state | meaning
// IDLE  | after reset, waiting for the first start
// RUN   | comparing stores against the expected queue
// DONE  | finished; status held until the next start
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    mem_write_checker_if.slave bus,
    input  logic              start,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("mem_write_checker: DEPTH must be a power of 2 and >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_write_checker: TIMEOUT must be >= 1");
    end

    state_t state;
    state_t state_next;
    logic   run;

    logic              q_full;
    logic              q_empty;
    logic [AW:0]       q_count;
    logic [ADDR_W+DATA_W-1:0] q_head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    logic push;
    logic wr_fire;
    logic hit;
    logic wr_err;
    logic drains;
    logic clear;
    logic tmo;

    assign push          = bus.exp_valid && !q_full;
    assign bus.exp_ready = !q_full;

    mwc_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({bus.exp_addr, bus.exp_data}),
        .pop       (wr_fire),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign head_addr = q_head[ADDR_W+DATA_W-1:DATA_W];
    assign head_data = q_head[DATA_W-1:0];

    assign wr_fire = run && bus.memwrite;
    // An empty queue never matches, even if a push lands in the same cycle.
    assign hit     = !q_empty && (head_addr == bus.dataadr) && (head_data == bus.writedata);
    assign wr_err  = wr_fire && !hit;
    // Queue is empty after this store: either it was already empty or it held
    // one entry that is being popped, and no push refills it.
    assign drains  = wr_fire && !push && (q_empty || q_count == {{AW{1'b0}}, 1'b1});
    assign clear   = start && (state != ST_RUN);

`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer;

    // Down-counter reloaded on arm and on every store; reaching zero while
    // still idle in RUN is the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (clear || wr_fire) begin
            timer <= TMR_W'(TIMEOUT - 1);
        end else if (run && timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    assign tmo = run && !bus.memwrite && (timer == '0);
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)          state_next = ST_RUN;
            ST_RUN:  if (drains || tmo)  state_next = ST_DONE;
            ST_DONE: if (start)          state_next = ST_RUN;
            default:                     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        run  = (state == ST_RUN);
        done = (state == ST_DONE);
        pass = done && (err_count == '0);
        fail = done && (err_count != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= '0;
            err_count   <= '0;
        end else if (clear) begin
            match_count <= '0;
            err_count   <= '0;
        end else begin
            if (wr_fire && hit && match_count != CNT_MAX) match_count <= match_count + 1'b1;
            if ((wr_err || tmo) && err_count != CNT_MAX)  err_count   <= err_count + 1'b1;
        end
    end

    // err_count is still zero only until the first error of this run. A
    // timeout has no observed store, so it leaves first_err_* untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (clear) begin
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (wr_err && err_count == '0) begin
            first_err_addr <= bus.dataadr;
            first_err_data <= bus.writedata;
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 16;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              done, pass, fail;
    logic [CNT_W-1:0]  match_count, err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] first_err_data;

    int checks = 0;
    int errors = 0;

    mem_write_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_write_checker #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .start          (start),
        .done           (done),
        .pass           (pass),
        .fail           (fail),
        .match_count    (match_count),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        bus.exp_valid = 1'b1;
        bus.exp_addr  = a;
        bus.exp_data  = d;
        step();
        bus.exp_valid = 1'b0;
    endtask

    task automatic write(input logic [15:0] a, input logic [7:0] d);
        bus.memwrite  = 1'b1;
        bus.dataadr   = a;
        bus.writedata = d;
        step();
        bus.memwrite  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        bus.memwrite = 0; bus.dataadr = 0; bus.writedata = 0;
        bus.exp_valid = 0; bus.exp_addr = 0; bus.exp_data = 0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if ({done, pass, fail} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {done, pass, fail}); end
        checks++; if (match_count !== 4'd0 || err_count !== 4'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", match_count, err_count); end
        checks++; if (first_err_addr !== 16'h0 || first_err_data !== 8'h0) begin errors++; $display("FAIL reset_first_err got %h/%h exp 0/0", first_err_addr, first_err_data); end
        checks++; if (bus.exp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.exp_ready); end
    endtask

    task automatic test_match();
        push(16'h001C, 8'hB9);
        pulse_start();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL match_running got done=%b exp 0", done); end
        write(16'h001C, 8'hB9);
        checks++; if ({done, pass, fail} !== 3'b110) begin errors++; $display("FAIL match_flags got %b exp 110", {done, pass, fail}); end
        checks++; if (match_count !== 4'd1 || err_count !== 4'd0) begin errors++; $display("FAIL match_counts got %0d/%0d exp 1/0", match_count, err_count); end
    endtask

    task automatic test_mismatch();
        push(16'h001C, 8'hB9);
        pulse_start();
        checks++; if (match_count !== 4'd0) begin errors++; $display("FAIL mismatch_clear got %0d exp 0", match_count); end
        write(16'h001C, 8'hB8);
        checks++; if ({done, pass, fail} !== 3'b101) begin errors++; $display("FAIL mismatch_flags got %b exp 101", {done, pass, fail}); end
        checks++; if (err_count !== 4'd1 || match_count !== 4'd0) begin errors++; $display("FAIL mismatch_counts got %0d/%0d exp 0/1", match_count, err_count); end
        checks++; if (first_err_addr !== 16'h001C || first_err_data !== 8'hB8) begin errors++; $display("FAIL mismatch_first_err got %h/%h exp 001c/b8", first_err_addr, first_err_data); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                checks++; if (bus.exp_ready !== 1'b1) begin errors++; $display("FAIL full_ready7 got %b exp 1", bus.exp_ready); end
            end
            push(16'h0100 + 16'(i), 8'h10 + 8'(i));
        end
        bus.exp_valid = 1'b1; bus.exp_addr = 16'h01FF; bus.exp_data = 8'hEE;
        #1;
        checks++; if (bus.exp_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.exp_ready); end
        step();
        bus.exp_valid = 1'b0;
        // store while DONE must not pop or count
        write(16'h0100, 8'h10);
        checks++; if (err_count !== 4'd1 || match_count !== 4'd0) begin errors++; $display("FAIL done_write_ignored got %0d/%0d exp 0/1", match_count, err_count); end
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_early_done got %b exp 0", done); end
            end
            write(16'h0100 + 16'(i), 8'h10 + 8'(i));
        end
        checks++; if (match_count !== 4'd8 || err_count !== 4'd0) begin errors++; $display("FAIL full_counts got %0d/%0d exp 8/0", match_count, err_count); end
        checks++; if ({done, pass, fail} !== 3'b110) begin errors++; $display("FAIL full_flags got %b exp 110", {done, pass, fail}); end
    endtask

    task automatic test_empty_start();
        pulse_start();
        step(); step(); step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_wait got done=%b exp 0", done); end
        write(16'h0010, 8'h01);
        checks++; if ({done, pass, fail} !== 3'b101) begin errors++; $display("FAIL empty_flags got %b exp 101", {done, pass, fail}); end
        checks++; if (err_count !== 4'd1 || match_count !== 4'd0) begin errors++; $display("FAIL empty_counts got %0d/%0d exp 0/1", match_count, err_count); end
        checks++; if (first_err_addr !== 16'h0010 || first_err_data !== 8'h01) begin errors++; $display("FAIL empty_first_err got %h/%h exp 0010/01", first_err_addr, first_err_data); end
    endtask

    task automatic test_no_bypass();
        pulse_start();
        bus.exp_valid = 1'b1; bus.exp_addr = 16'h0040; bus.exp_data = 8'h44;
        write(16'h0040, 8'h44);
        bus.exp_valid = 1'b0;
        checks++; if (err_count !== 4'd1 || match_count !== 4'd0 || done !== 1'b0) begin errors++; $display("FAIL bypass_first got m=%0d e=%0d d=%b exp 0/1/0", match_count, err_count, done); end
        write(16'h0040, 8'h44);
        checks++; if (match_count !== 4'd1 || {done, fail} !== 2'b11) begin errors++; $display("FAIL bypass_second got m=%0d df=%b exp 1/11", match_count, {done, fail}); end
    endtask

    task automatic test_saturate();
        push(16'h0200, 8'h00);
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            bus.exp_valid = 1'b1; bus.exp_addr = 16'h0200; bus.exp_data = 8'h00;
            write(16'h0300, 8'(i + 1));
        end
        bus.exp_valid = 1'b0;
        checks++; if (err_count !== 4'd15 || done !== 1'b0) begin errors++; $display("FAIL sat_count got e=%0d d=%b exp 15/0", err_count, done); end
        checks++; if (first_err_addr !== 16'h0300 || first_err_data !== 8'h01) begin errors++; $display("FAIL sat_first_err got %h/%h exp 0300/01", first_err_addr, first_err_data); end
        write(16'h0301, 8'h77);
        checks++; if (err_count !== 4'd15 || {done, fail} !== 2'b11) begin errors++; $display("FAIL sat_final got e=%0d df=%b exp 15/11", err_count, {done, fail}); end
    endtask

    task automatic test_timeout();
        int seen;
        seen = 0;
        push(16'h0500, 8'h50);
        pulse_start();
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done === 1'b1 && seen == 0) seen = i;
        end
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
        checks++; if (seen != 16) begin errors++; $display("FAIL timeout_cycle got %0d exp 16", seen); end
        checks++; if (err_count !== 4'd1 || fail !== 1'b1) begin errors++; $display("FAIL timeout_err got e=%0d f=%b exp 1/1", err_count, fail); end
`else
        checks++; if (seen != 0) begin errors++; $display("FAIL no_timeout got done at %0d exp never", seen); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL no_timeout_err got %0d exp 0", err_count); end
`endif
    endtask

    task automatic test_reset_mid_run();
        push(16'h0501, 8'h51);
        push(16'h0502, 8'h52);
        push(16'h0503, 8'h53);
        pulse_start();
        write(16'h0500, 8'hFF);
        checks++; if (err_count !== 4'd1 || done !== 1'b0) begin errors++; $display("FAIL pre_reset got e=%0d d=%b exp 1/0", err_count, done); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({done, pass, fail} !== 3'b000 || match_count !== 4'd0 || err_count !== 4'd0) begin errors++; $display("FAIL midrun_reset got f=%b m=%0d e=%0d exp 000/0/0", {done, pass, fail}, match_count, err_count); end
        checks++; if (first_err_addr !== 16'h0 || first_err_data !== 8'h0 || bus.exp_ready !== 1'b1) begin errors++; $display("FAIL midrun_reset2 got %h/%h r=%b exp 0/0/1", first_err_addr, first_err_data, bus.exp_ready); end
        step();
        reset = 1'b0;
        write(16'h0501, 8'h51);
        checks++; if (err_count !== 4'd0 || match_count !== 4'd0 || done !== 1'b0) begin errors++; $display("FAIL idle_write got m=%0d e=%0d d=%b exp 0/0/0", match_count, err_count, done); end
        pulse_start();
        write(16'h0501, 8'h51);
        checks++; if (err_count !== 4'd1 || match_count !== 4'd0 || {done, fail} !== 2'b11) begin errors++; $display("FAIL discard got m=%0d e=%0d df=%b exp 0/1/11", match_count, err_count, {done, fail}); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_full();
        test_empty_start();
        test_no_bypass();
        test_saturate();
        test_timeout();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
